// File: rtl/midi_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// midi_tx_ctrl_pkg
// Shared definitions for the MIDI UART transmit path (31250 baud, 8N1).
// Holds the frame state encoding, which is also used by the receive side,
// plus the default divider settings and the frame geometry.
// -----------------------------------------------------------------------------
package midi_tx_ctrl_pkg;

  // Frame sequencer states. The encodings are fixed because the receive
  // block and the debug tooling decode them numerically.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // 1 MHz system clock / 32 = 31250 baud.
  localparam int MIDI_DIV_DEFAULT  = 32;
  localparam int MIDI_DIVW_DEFAULT = 5;

  // 8N1 framing: one start bit, eight data bits, one stop bit.
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;

endpackage

// File: rtl/midi_tx_ctrl_reg.sv
// -----------------------------------------------------------------------------
// midi_tx_ctrl_reg
// Generic enable-loaded register, used as the transmit holding register.
// Updates on the falling clock edge to match the rest of the MIDI path.
// Ports:
//   clock  in  1      system clock (state changes on falling edge)
//   reset  in  1      asynchronous, active-high; loads RESET
//   en     in  1      load enable
//   d      in  WIDTH  data to load
//   q      out WIDTH  registered value
// -----------------------------------------------------------------------------
module midi_tx_ctrl_reg #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      q_q <= RESET;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/midi_tx_ctrl.sv
// -----------------------------------------------------------------------------
// midi_tx_ctrl
// Transmit controller for the MIDI UART path (8N1). Sequences a transmit
// holding register (THR) into a shift register and drives the serial line,
// plus the CPU-visible status and interrupt bits.
// Ports:
//   clock      in   1  system clock; all state updates on the falling edge
//   reset      in   1  asynchronous, active-high reset
//   wr         in   1  CPU data-register write strobe (one clock wide)
//   din        in   8  CPU write data
//   rd_stat    in   1  CPU status-read strobe (one clock wide); clears ovr
//   irq_en     in   1  transmit interrupt enable
//   txd        out  1  serial output, idle/mark = 1
//   thr_empty  out  1  THR can accept a byte
//   busy       out  1  frame in progress (start through stop bit)
//   ovr        out  1  sticky overrun flag
//   irq        out  1  registered irq_en & thr_empty
//   state_dbg  out  2  current sequencer state, for observation only
// -----------------------------------------------------------------------------
module midi_tx_ctrl
  import midi_tx_ctrl_pkg::*;
#(
  parameter int DIV  = MIDI_DIV_DEFAULT,
  parameter int DIVW = MIDI_DIVW_DEFAULT
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      wr,
  input  logic [7:0] din,
  input  logic      rd_stat,
  input  logic      irq_en,
  output logic      txd,
  output logic      thr_empty,
  output logic      busy,
  output logic      ovr,
  output logic      irq,
  output tx_state_e state_dbg
);

  localparam logic [DIVW-1:0] CNT_LAST = DIVW'(DIV - 1);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shifter_q, shifter_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        thr_empty_q, thr_empty_d;
  logic        ovr_q, ovr_d;
  logic        irq_q, irq_d;

  logic [7:0]  thr;
  logic        bit_end;
  logic        load;
  logic        accept;
  logic        thr_we;

  // CPU write handshake: wr is a one-clock strobe with no back-pressure.
  // A write is accepted when the THR is empty, or when the THR is being
  // moved into the shifter on the same edge (the shifter takes the old THR
  // contents and the THR takes din). Any other write is dropped and flags
  // an overrun; software learns about it through ovr, never via a stall.
  assign bit_end = (cnt_q == CNT_LAST);
  assign load    = !thr_empty_q &&
                   ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign accept  = thr_empty_q || load;
  assign thr_we  = wr && accept;

  midi_tx_ctrl_reg #(
    .WIDTH (8),
    .RESET (8'h00)
  ) u_thr (
    .clock (clock),
    .reset (reset),
    .en    (thr_we),
    .d     (din),
    .q     (thr)
  );

  // Frame sequencer, divider, bit counter and shifter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shifter_d = shifter_q;
    txd_d     = txd_q;
    busy_d    = busy_q;

    // The divider free-runs 0..DIV-1 for as long as a frame is on the line.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          txd_d     = shifter_q[0];
          shifter_d = {1'b0, shifter_q[7:1]};
          bit_d     = '0;
        end
      end
      S_DATA: begin
        // bit_q is the index of the data bit currently on the line.
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d     = shifter_q[0];
            shifter_d = {1'b0, shifter_q[7:1]};
            bit_d     = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load overrides the above, which gives back-to-back frames with no
    // idle clock when the THR is already full at the end of the stop bit.
    if (load) begin
      state_d   = S_START;
      cnt_d     = '0;
      shifter_d = thr;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
    end
  end

  // Status flags.
  always_comb begin
    thr_empty_d = thr_empty_q;
    if (load) begin
      thr_empty_d = 1'b1;
    end
    // Same-edge write and load leave the THR full with the new byte.
    if (thr_we) begin
      thr_empty_d = 1'b0;
    end

    ovr_d = ovr_q;
    if (rd_stat) begin
      ovr_d = 1'b0;
    end
    // A fresh overrun wins over a simultaneous status read.
    if (wr && !accept) begin
      ovr_d = 1'b1;
    end

    irq_d = irq_en && thr_empty_q;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shifter_q   <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      thr_empty_q <= 1'b1;
      ovr_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shifter_q   <= shifter_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      thr_empty_q <= thr_empty_d;
      ovr_q       <= ovr_d;
      irq_q       <= irq_d;
    end
  end

  assign txd       = txd_q;
  assign thr_empty = thr_empty_q;
  assign busy      = busy_q;
  assign ovr       = ovr_q;
  assign irq       = irq_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_midi_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_midi_tx_ctrl
// Directed bench for midi_tx_ctrl with DIV=4. The DUT updates on the falling
// edge; the bench drives inputs and samples outputs on the rising edge.
// -----------------------------------------------------------------------------
module tb_midi_tx_ctrl;
  import midi_tx_ctrl_pkg::*;

  localparam int DIV   = 4;
  localparam int DIVW  = 2;
  localparam int FRAME = 10 * DIV;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic      clock;
  logic      reset;
  logic      wr;
  logic [7:0] din;
  logic      rd_stat;
  logic      irq_en;
  logic      txd;
  logic      thr_empty;
  logic      busy;
  logic      ovr;
  logic      irq;
  tx_state_e state_dbg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  midi_tx_ctrl #(
    .DIV  (DIV),
    .DIVW (DIVW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr        (wr),
    .din       (din),
    .rd_stat   (rd_stat),
    .irq_en    (irq_en),
    .txd       (txd),
    .thr_empty (thr_empty),
    .busy      (busy),
    .ovr       (ovr),
    .irq       (irq),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int   total = 0;
  int   bad   = 0;
  logic te_s  [FRAME];
  logic irq_s [FRAME];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Pulse wr for one clock starting at the current rising edge.
  task automatic write_byte(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    @(posedge clock);
    wr  = 1'b0;
  endtask

  // Check one full frame. Sample k is taken after the k-th falling edge
  // following the load edge. If pre is set, the current rising edge is
  // already sample 0. A one-clock write of wr_byte is driven at sample wr_at.
  task automatic run_frame(input logic [7:0] b, input bit pre, input int wr_at,
                           input logic [7:0] wr_byte);
    for (int k = 0; k < FRAME; k++) begin
      if (!(pre && k == 0)) @(posedge clock);
      te_s[k]  = thr_empty;
      irq_s[k] = irq;
      check($sformatf("frame_%02h_s%0d", b, k), 32'({busy, txd}),
            32'({1'b1, exp_bit(b, k / DIV)}));
      wr  = (k == wr_at);
      din = wr_byte;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset   = 1'b1;
    wr      = 1'b0;
    din     = 8'h00;
    rd_stat = 1'b0;
    irq_en  = 1'b0;
    repeat (3) @(posedge clock);

    // 1: reset state
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_thr_empty", 32'(thr_empty), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    reset = 1'b0;
    @(posedge clock);
    check("idle_txd", 32'(txd), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // 2: single frame 0x55
    write_byte(8'h55);
    check("t2_thr_full", 32'(thr_empty), 32'd0);
    check("t2_not_busy_yet", 32'({busy, txd}), 32'b01);
    run_frame(8'h55, 1'b0, -1, 8'h00);
    check("t2_thr_empty_s0", 32'(te_s[0]), 32'd1);
    @(posedge clock);
    check("t2_idle_after", 32'({busy, txd}), 32'b01);
    check("t2_state_idle", 32'(state_dbg), 32'(S_IDLE));

    // 3: back-to-back 0xA5 then 0x3C
    write_byte(8'hA5);
    run_frame(8'hA5, 1'b0, 10, 8'h3C);
    check("t3_thr_full_mid", 32'(te_s[11]), 32'd0);
    run_frame(8'h3C, 1'b0, -1, 8'h00);
    check("t3_ovr", 32'(ovr), 32'd0);
    @(posedge clock);
    check("t3_idle_after", 32'({busy, txd}), 32'b01);

    // 4: three consecutive writes, third dropped
    wr = 1'b1; din = 8'h11;
    @(posedge clock);
    din = 8'h22;
    @(posedge clock);
    run_frame(8'h11, 1'b1, 0, 8'h33);
    check("t4_thr_full", 32'(te_s[5]), 32'd0);
    check("t4_ovr_set", 32'(ovr), 32'd1);
    run_frame(8'h22, 1'b0, -1, 8'h00);
    check("t4_ovr_sticky", 32'(ovr), 32'd1);
    check("t4_thr_empty", 32'(thr_empty), 32'd1);
    @(posedge clock);
    rd_stat = 1'b1;
    @(posedge clock);
    rd_stat = 1'b0;
    check("t4_ovr_clear", 32'(ovr), 32'd0);

    // 4b: overrun and status read on the same edge, set wins
    wr = 1'b1; din = 8'h44;
    @(posedge clock);
    din = 8'h45;
    @(posedge clock);
    din = 8'h46; rd_stat = 1'b1;
    @(posedge clock);
    wr = 1'b0; rd_stat = 1'b0;
    check("t4b_ovr_set_wins", 32'(ovr), 32'd1);
    repeat (78) @(posedge clock);
    check("t4b_busy_end", 32'(busy), 32'd1);
    @(posedge clock);
    check("t4b_idle", 32'({busy, txd}), 32'b01);
    rd_stat = 1'b1;
    @(posedge clock);
    rd_stat = 1'b0;
    check("t4b_ovr_clear", 32'(ovr), 32'd0);

    // 5: asynchronous reset in the middle of 0xF0
    write_byte(8'hF0);
    repeat (18) @(posedge clock);
    check("t5_data3", 32'({busy, txd}), 32'b10);
    repeat (4) @(posedge clock);
    check("t5_data4", 32'({busy, txd}), 32'b11);
    #2 reset = 1'b1;
    #1;
    check("t5_async_txd", 32'(txd), 32'd1);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_thr", 32'(thr_empty), 32'd1);
    check("t5_async_state", 32'(state_dbg), 32'(S_IDLE));
    wr = 1'b1; din = 8'hEE;
    @(posedge clock);
    @(posedge clock);
    wr = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    check("t5_wr_in_reset", 32'({busy, thr_empty, txd}), 32'b011);
    write_byte(8'h90);
    run_frame(8'h90, 1'b0, -1, 8'h00);
    @(posedge clock);
    check("t5_idle_after", 32'({busy, txd}), 32'b01);

    // 6: interrupt with a write on the stop->start load edge
    irq_en = 1'b1;
    @(posedge clock);
    check("t6_irq_idle", 32'(irq), 32'd1);
    wr = 1'b1; din = 8'hA1;
    @(posedge clock);
    din = 8'hB2;
    @(posedge clock);
    run_frame(8'hA1, 1'b1, FRAME - 1, 8'hC3);
    check("t6_irq_low_a1", 32'(irq_s[20]), 32'd0);
    run_frame(8'hB2, 1'b0, -1, 8'h00);
    check("t6_thr_kept_full", 32'(te_s[0]), 32'd0);
    check("t6_irq_low_b2", 32'(irq_s[20]), 32'd0);
    check("t6_ovr", 32'(ovr), 32'd0);
    run_frame(8'hC3, 1'b0, -1, 8'h00);
    check("t6_thr_empty_c3", 32'(te_s[0]), 32'd1);
    check("t6_irq_lag", 32'(irq_s[0]), 32'd0);
    check("t6_irq_back", 32'(irq_s[1]), 32'd1);
    wr = 1'b0;
    @(posedge clock);
    check("t6_idle_after", 32'({busy, txd, irq}), 32'b011);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound so the bench always ends on its own.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
